rpn_stack_ctrl: RTL and testbench

Operand-stack controller and operation sequencer for the RPN calculator. Accepts one command at a time (push a switch value, or apply an operator) and owns the operand stack. It sequences each command through a fixed read/write-back FSM and drives the top-of-stack value and error flags toward the LED/HEX display logic. It sits between the debounced KEY/SW front end and the display decoders.

---
 rtl/rpn_stack_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_ctrl.sv
// Operand-stack controller for the RPN calculator: accepts one command at a time and
// sequences it through IDLE -> RD -> WB, committing the result to the stack on the WB edge.
module rpn_stack_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       CLOCK_50,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  input  logic [2:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_data,
  output logic                       cmd_ready,
  output logic                       done,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_ovf,
  output logic                       err_unf
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRd   = 2'd1;
  localparam logic [1:0] StWb   = 2'd2;

  localparam logic [2:0] OpPush  = 3'd0;
  localparam logic [2:0] OpAdd   = 3'd1;
  localparam logic [2:0] OpSub   = 3'd2;
  localparam logic [2:0] OpMul   = 3'd3;
  localparam logic [2:0] OpDrop  = 3'd4;
  localparam logic [2:0] OpDup   = 3'd5;
  localparam logic [2:0] OpSwap  = 3'd6;
  localparam logic [2:0] OpClear = 3'd7;

  logic             rst_sync_q;
  logic [1:0]       state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             ovf_pend_q;
  logic             unf_pend_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] top_q;
  logic             ovf_q;
  logic             unf_q;
  logic             done_q;
  logic [WIDTH-1:0] stk_q [DEPTH];

  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             chk_ovf;
  logic             chk_unf;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    count_nx;
  logic [WIDTH-1:0] top_nx;
  logic [DEPTH-1:0] wr_en;
  logic [WIDTH-1:0] wr_val [DEPTH];

  // Single-stage release sync so the first accept can land on the second edge after release.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= 1'b1;
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CW'(i + 1)) rd_b = stk_q[i];
      if (count_q == CW'(i + 2)) rd_a = stk_q[i];
    end
  end

  always_comb begin
    chk_ovf = 1'b0;
    chk_unf = 1'b0;
    case (op_q)
      OpPush: chk_ovf = (count_q == CW'(DEPTH));
      OpDup: begin
        chk_ovf = (count_q == CW'(DEPTH));
        chk_unf = (count_q == '0);
      end
      OpDrop: chk_unf = (count_q == '0);
      OpAdd, OpSub, OpMul, OpSwap: chk_unf = (count_q < CW'(2));
      default: ;
    endcase
  end

  always_comb begin
    res = '0;
    case (op_q)
      OpAdd:   res = a_q + b_q;
      OpSub:   res = a_q - b_q;
      OpMul:   res = a_q * b_q;
      default: ;
    endcase
  end

  // Next count/top and per-entry writes for a legal command; applied only on the WB edge.
  always_comb begin
    count_nx = count_q;
    top_nx   = top_q;
    wr_en    = '0;
    for (int i = 0; i < DEPTH; i++) wr_val[i] = '0;
    case (op_q)
      OpPush: begin
        count_nx = count_q + CW'(1);
        top_nx   = data_q;
      end
      OpDup: begin
        count_nx = count_q + CW'(1);
        top_nx   = b_q;
      end
      OpAdd, OpSub, OpMul: begin
        count_nx = count_q - CW'(1);
        top_nx   = res;
      end
      OpDrop: begin
        count_nx = count_q - CW'(1);
        top_nx   = a_q;
      end
      OpSwap: top_nx = a_q;
      default: ;
    endcase
    for (int i = 0; i < DEPTH; i++) begin
      case (op_q)
        OpPush, OpDup: begin
          if (count_q == CW'(i)) begin
            wr_en[i]  = 1'b1;
            wr_val[i] = (op_q == OpPush) ? data_q : b_q;
          end
        end
        OpAdd, OpSub, OpMul: begin
          if (count_q == CW'(i + 2)) begin
            wr_en[i]  = 1'b1;
            wr_val[i] = res;
          end
        end
        OpSwap: begin
          if (count_q == CW'(i + 1)) begin
            wr_en[i]  = 1'b1;
            wr_val[i] = a_q;
          end
          if (count_q == CW'(i + 2)) begin
            wr_en[i]  = 1'b1;
            wr_val[i] = b_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q    <= StIdle;
      op_q       <= '0;
      data_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ovf_pend_q <= 1'b0;
      unf_pend_q <= 1'b0;
      count_q    <= '0;
      top_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            data_q  <= cmd_data;
            state_q <= StRd;
          end
        end
        StRd: begin
          a_q        <= rd_a;
          b_q        <= rd_b;
          ovf_pend_q <= chk_ovf;
          unf_pend_q <= chk_unf;
          state_q    <= StWb;
        end
        StWb: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
          if (op_q == OpClear) begin
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
          end else if (ovf_pend_q || unf_pend_q) begin
            if (ovf_pend_q) ovf_q <= 1'b1;
            if (unf_pend_q) unf_q <= 1'b1;
          end else begin
            count_q <= count_nx;
            top_q   <= top_nx;
            for (int i = 0; i < DEPTH; i++) begin
              if (wr_en[i]) stk_q[i] <= wr_val[i];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign done      = done_q;
  assign top       = top_q;
  assign count     = count_q;
  assign err_ovf   = ovf_q;
  assign err_unf   = unf_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed bench for rpn_stack_ctrl: reset behaviour, arithmetic, wrap, overflow/underflow
// and back-to-back command throughput with hand-computed expectations.
module tb_rpn_stack_ctrl;

  localparam logic [2:0] PUSH  = 3'd0;
  localparam logic [2:0] ADD   = 3'd1;
  localparam logic [2:0] SUB   = 3'd2;
  localparam logic [2:0] MUL   = 3'd3;
  localparam logic [2:0] DROP  = 3'd4;
  localparam logic [2:0] DUP   = 3'd5;
  localparam logic [2:0] SWAP  = 3'd6;
  localparam logic [2:0] CLEAR = 3'd7;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_ready;
  logic       done;
  logic [7:0] top;
  logic [3:0] count;
  logic       err_ovf;
  logic       err_unf;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  rpn_stack_ctrl #(
    .WIDTH(8),
    .DEPTH(8)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .done     (done),
    .top      (top),
    .count    (count),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
  );

  // One command with its handshake and done timing; returns just after the commit edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] d);
    @(negedge CLOCK_50);
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready op=%0d: cmd_ready=%b want 1", op, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge CLOCK_50); #1;
    cmd_valid = 1'b0;
    n_chk++;
    if ({cmd_ready, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL issue_rd op=%0d: ready,done=%b want 00", op, {cmd_ready, done});
    end
    @(posedge CLOCK_50); #1;
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_wb op=%0d: done=%b want 0", op, done);
    end
    @(posedge CLOCK_50); #1;
    n_chk++;
    if ({done, cmd_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL issue_done op=%0d: done,ready=%b want 11", op, {done, cmd_ready});
    end
  endtask

  task automatic test_reset();
    logic seen_done;
    rst_n = 1'b0;
    #12;
    n_chk++;
    if ({cmd_ready, done, top, count, err_ovf, err_unf} !== {1'b1, 1'b0, 8'd0, 4'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b done=%b top=%0d count=%0d ovf=%b unf=%b want 1 0 0 0 0 0",
               cmd_ready, done, top, count, err_ovf, err_unf);
    end
    // Request waiting at release: first edge must not accept, second must.
    @(negedge CLOCK_50);
    cmd_valid = 1'b1;
    cmd_op    = PUSH;
    cmd_data  = 8'd9;
    rst_n     = 1'b1;
    @(posedge CLOCK_50); #1;
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_edge1: cmd_ready=%b want 1", cmd_ready);
    end
    @(posedge CLOCK_50); #1;
    cmd_valid = 1'b0;
    n_chk++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_edge2_accept: cmd_ready=%b want 0", cmd_ready);
    end
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1;
    n_chk++;
    if ({done, top, count} !== {1'b1, 8'd9, 4'd1}) begin
      n_fail++;
      $display("FAIL reset_first_push: done=%b top=%0d count=%0d want 1 9 1", done, top, count);
    end
    // Reset asserted while a command sits in RD.
    @(negedge CLOCK_50);
    cmd_valid = 1'b1;
    cmd_op    = PUSH;
    cmd_data  = 8'd4;
    @(posedge CLOCK_50); #1;
    cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({cmd_ready, done, top, count, err_ovf, err_unf} !== {1'b1, 1'b0, 8'd0, 4'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_mid_cmd: ready=%b done=%b top=%0d count=%0d ovf=%b unf=%b want 1 0 0 0 0 0",
               cmd_ready, done, top, count, err_ovf, err_unf);
    end
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge CLOCK_50); #1;
      if (done !== 1'b0) seen_done = 1'b1;
    end
    n_chk++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: done pulse seen=%b want 0", seen_done);
    end
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(posedge CLOCK_50);
  endtask

  task automatic test_arith();
    issue(PUSH, 8'd41);
    issue(PUSH, 8'd3);
    issue(ADD, 8'd0);
    n_chk++;
    if ({top, count} !== {8'd44, 4'd1}) begin
      n_fail++;
      $display("FAIL arith_add: top=%0d count=%0d want 44 1", top, count);
    end
    issue(PUSH, 8'd5);
    issue(SUB, 8'd0);
    n_chk++;
    if ({top, count} !== {8'd39, 4'd1}) begin
      n_fail++;
      $display("FAIL arith_sub: top=%0d count=%0d want 39 1", top, count);
    end
    issue(PUSH, 8'd6);
    issue(MUL, 8'd0);
    n_chk++;
    if ({top, count, err_ovf, err_unf} !== {8'd234, 4'd1, 2'b00}) begin
      n_fail++;
      $display("FAIL arith_mul: top=%0d count=%0d ovf=%b unf=%b want 234 1 0 0",
               top, count, err_ovf, err_unf);
    end
  endtask

  task automatic test_wrap();
    issue(CLEAR, 8'd0);
    issue(PUSH, 8'd200);
    issue(PUSH, 8'd100);
    issue(ADD, 8'd0);
    n_chk++;
    if ({top, count} !== {8'd44, 4'd1}) begin
      n_fail++;
      $display("FAIL wrap_add: top=%0d count=%0d want 44 1", top, count);
    end
    issue(CLEAR, 8'd0);
    issue(PUSH, 8'd3);
    issue(PUSH, 8'd5);
    issue(SUB, 8'd0);
    n_chk++;
    if ({top, count} !== {8'd254, 4'd1}) begin
      n_fail++;
      $display("FAIL wrap_sub: top=%0d count=%0d want 254 1", top, count);
    end
    issue(CLEAR, 8'd0);
    issue(PUSH, 8'd16);
    issue(DUP, 8'd0);
    issue(MUL, 8'd0);
    n_chk++;
    if ({top, count, err_ovf, err_unf} !== {8'd0, 4'd1, 2'b00}) begin
      n_fail++;
      $display("FAIL wrap_mul: top=%0d count=%0d ovf=%b unf=%b want 0 1 0 0",
               top, count, err_ovf, err_unf);
    end
  endtask

  task automatic test_overflow();
    issue(CLEAR, 8'd0);
    for (int i = 0; i < 8; i++) issue(PUSH, 8'(i * 10 + 1));
    n_chk++;
    if ({top, count, err_ovf} !== {8'd71, 4'd8, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_fill: top=%0d count=%0d ovf=%b want 71 8 0", top, count, err_ovf);
    end
    issue(PUSH, 8'd99);
    n_chk++;
    if ({top, count, err_ovf, err_unf} !== {8'd71, 4'd8, 2'b10}) begin
      n_fail++;
      $display("FAIL ovf_push: top=%0d count=%0d ovf=%b unf=%b want 71 8 1 0",
               top, count, err_ovf, err_unf);
    end
    issue(DROP, 8'd0);
    n_chk++;
    if ({top, count, err_ovf} !== {8'd61, 4'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_drop: top=%0d count=%0d ovf=%b want 61 7 1", top, count, err_ovf);
    end
    issue(CLEAR, 8'd0);
    n_chk++;
    if ({top, count, err_ovf, err_unf} !== {8'd0, 4'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL ovf_clear: top=%0d count=%0d ovf=%b unf=%b want 0 0 0 0",
               top, count, err_ovf, err_unf);
    end
  endtask

  task automatic test_underflow();
    issue(DROP, 8'd0);
    n_chk++;
    if ({top, count, err_ovf, err_unf} !== {8'd0, 4'd0, 2'b01}) begin
      n_fail++;
      $display("FAIL unf_drop: top=%0d count=%0d ovf=%b unf=%b want 0 0 0 1",
               top, count, err_ovf, err_unf);
    end
    issue(PUSH, 8'd7);
    issue(ADD, 8'd0);
    n_chk++;
    if ({top, count, err_unf} !== {8'd7, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL unf_add: top=%0d count=%0d unf=%b want 7 1 1", top, count, err_unf);
    end
    issue(PUSH, 8'd9);
    issue(SWAP, 8'd0);
    n_chk++;
    if ({top, count} !== {8'd7, 4'd2}) begin
      n_fail++;
      $display("FAIL swap_top: top=%0d count=%0d want 7 2", top, count);
    end
    issue(DROP, 8'd0);
    n_chk++;
    if ({top, count} !== {8'd9, 4'd1}) begin
      n_fail++;
      $display("FAIL swap_a: top=%0d count=%0d want 9 1", top, count);
    end
    issue(CLEAR, 8'd0);
    issue(DUP, 8'd0);
    n_chk++;
    if ({top, count, err_ovf, err_unf} !== {8'd0, 4'd0, 2'b01}) begin
      n_fail++;
      $display("FAIL unf_dup: top=%0d count=%0d ovf=%b unf=%b want 0 0 0 1",
               top, count, err_ovf, err_unf);
    end
    issue(CLEAR, 8'd0);
  endtask

  task automatic test_back_to_back();
    logic       pre;
    logic [9:0] acc;
    acc = '0;
    @(negedge CLOCK_50);
    cmd_valid = 1'b1;
    cmd_op    = PUSH;
    cmd_data  = 8'd1;
    for (int i = 0; i < 10; i++) begin
      pre = cmd_ready;
      @(posedge CLOCK_50); #1;
      if (pre && !cmd_ready) acc[i] = 1'b1;
      if (i == 9) cmd_valid = 1'b0;
      @(negedge CLOCK_50);
    end
    n_chk++;
    if (acc !== 10'b1001001001) begin
      n_fail++;
      $display("FAIL b2b_accepts: accept edges=%b want 1001001001", acc);
    end
    repeat (3) @(posedge CLOCK_50);
    #1;
    n_chk++;
    if ({top, count} !== {8'd1, 4'd4}) begin
      n_fail++;
      $display("FAIL b2b_count: top=%0d count=%0d want 1 4", top, count);
    end
    // Request left high through RD/WB with different data must not start a second command.
    @(negedge CLOCK_50);
    cmd_valid = 1'b1;
    cmd_data  = 8'd2;
    @(posedge CLOCK_50); #1;
    cmd_data = 8'd77;
    @(posedge CLOCK_50); #1;
    cmd_valid = 1'b0;
    @(posedge CLOCK_50); #1;
    n_chk++;
    if ({done, top, count} !== {1'b1, 8'd2, 4'd5}) begin
      n_fail++;
      $display("FAIL b2b_ignore: done=%b top=%0d count=%0d want 1 2 5", done, top, count);
    end
    repeat (3) @(posedge CLOCK_50);
    #1;
    n_chk++;
    if ({cmd_ready, top, count} !== {1'b1, 8'd2, 4'd5}) begin
      n_fail++;
      $display("FAIL b2b_settled: ready=%b top=%0d count=%0d want 1 2 5", cmd_ready, top, count);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_wrap();
    test_overflow();
    test_underflow();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
